regfile_access_ctrl: RTL
========================

Name: regfile_access_ctrl

Overview:
Sequencer and arbiter that owns the register file's write port (AD3/WE3/WD3) and its first read port (AD1). After reset it clears x1..x31 to zero while stalling the pipeline. It then passes pipeline writeback through, and services a single-outstanding debug read/write port by stalling the pipeline and borrowing the register file ports. It sits between the writeback stage, the decode stage and the register file.

Parameters:
DATA_WIDTH, 32, register/data width (matches register file width)
SP_INIT, 32'h0001_FFFC, x2 value loaded during clear (only with REGFILE_SP_INIT_EN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wb_we  in  1  pipeline writeback enable
wb_addr  in  5  pipeline writeback register
wb_data  in  DATA_WIDTH  pipeline writeback data
pipe_ad1  in  5  decode-stage read address 1
dbg_req  in  1  debug request, held until dbg_ack
dbg_we  in  1  debug write (1) / read (0)
dbg_addr  in  5  debug register index
dbg_wdata  in  DATA_WIDTH  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_WIDTH  debug read result, valid with dbg_ack, held until next ack
rf_we3  out  1  to register file WE3
rf_ad3  out  5  to register file AD3
rf_wd3  out  DATA_WIDTH  to register file WD3
rf_ad1  out  5  to register file AD1
rf_rd1  in  DATA_WIDTH  from register file RD1
stall  out  1  freeze pipeline registers
clear_done  out  1  high once the post-reset clear has completed

Behaviour:
- Interface: one clock `clk`; `rst` is asynchronous, active-high.
- FSM states: CLEAR, IDLE, DRAIN, ACCESS, ACK. State, counter and dbg_rdata are registered on posedge clk. All rf_* outputs are combinational from the state.
- Reset values: state=CLEAR, clr_cnt=1, dbg_ack=0, dbg_rdata=0, clear_done=0. stall=1 while in CLEAR.
- CLEAR:
  - Outputs: rf_we3=1, rf_ad3=clr_cnt, rf_wd3=0, rf_ad1=pipe_ad1, stall=1. wb_* is ignored.
  - clr_cnt increments 1→31. The cycle that writes x31 transitions to IDLE, so the clear takes exactly 31 cycles.
  - clear_done is set on entering IDLE and stays 1 until reset.
- IDLE:
  - Pass-through: rf_we3=wb_we, rf_ad3=wb_addr, rf_wd3=wb_data, rf_ad1=pipe_ad1, stall=0.
  - dbg_req=1 → DRAIN.
- DRAIN (1 cycle):
  - stall=1. Writeback is still passed through so the in-flight write commits.
  - Next state is ACCESS.
- ACCESS (1 cycle):
  - stall=1, rf_ad1=dbg_addr. wb_we is gated off; the pipeline inserts WB bubbles while stalled.
  - If dbg_we: rf_we3=1, rf_ad3=dbg_addr, rf_wd3=dbg_wdata. Otherwise rf_we3=0.
  - dbg_rdata <= rf_rd1. Because the register file forwards internally, a write returns dbg_wdata, and x0 returns 0.
  - Next state is ACK.
- ACK (1 cycle):
  - dbg_ack=1, stall=1, rf_we3=0, rf_ad1=pipe_ad1.
  - Next state is IDLE.
- Total stall per debug access: 3 cycles (DRAIN, ACCESS, ACK).
- Boundary conditions:
  - dbg_req during CLEAR: left pending and serviced from IDLE after the clear.
  - dbg_req dropped before ack: the transaction still completes and acks.
  - dbg_req still high in the IDLE cycle after ACK: treated as a new request.
  - Debug write to x0: WE3 is asserted, the register file discards it, and the read back is 0.
  - rst during any state: immediate return to CLEAR with clr_cnt=1. No ack is issued, clear_done=0, and the clear restarts from x1.

Optional Feature:
REGFILE_SP_INIT_EN:
- Defined: the CLEAR cycle with clr_cnt=2 drives rf_wd3=SP_INIT instead of 0, so x2 (sp) holds SP_INIT after the clear. All other registers clear to 0 and CLEAR length is unchanged.
- Undefined: every register x1..x31 is cleared to 0, and SP_INIT is unused.

Test Plan:
1. Release rst → rf_we3=1 with rf_ad3=1..31 over 31 consecutive cycles, rf_wd3=0, stall=1; the next cycle has stall=0 and clear_done=1. With REGFILE_SP_INIT_EN, x2 reads 32'h0001_FFFC.
2. IDLE, wb_we=1, wb_addr=5, wb_data=32'hDEADBEEF → same cycle rf_we3=1, rf_ad3=5, rf_wd3=32'hDEADBEEF, stall=0.
3. Debug write: dbg_req=1, dbg_we=1, dbg_addr=10, dbg_wdata=32'h12345678 → DRAIN, then ACCESS with rf_we3=1 and rf_ad3=10, then ACK with dbg_rdata=32'h12345678. Register file a0=32'h12345678; stall high for exactly 3 cycles.
4. Debug read of x7 issued while WB writes x7=32'h55 in the DRAIN cycle → dbg_rdata=32'h55.
5. dbg_req raised at CLEAR cycle 5 for a read of x3 → no action until IDLE, then ack with dbg_rdata=0. Separately, a read of x0 after writing x0=32'hFFFFFFFF returns 0.
6. rst pulsed during ACCESS → dbg_ack never pulses, state=CLEAR, and the clear resumes at rf_ad3=1 after release.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// Register file write-port/read-port-1 owner: post-reset clear, writeback pass-through, debug access.
// Optional: define REGFILE_SP_INIT_EN to load SP_INIT into x2 during the clear.
module regfile_access_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = DATA_WIDTH'(32'h0001_FFFC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [4:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [4:0]            pipe_ad1,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [4:0]            dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  rf_we3,
  output logic [4:0]            rf_ad3,
  output logic [DATA_WIDTH-1:0] rf_wd3,
  output logic [4:0]            rf_ad1,
  input  logic [DATA_WIDTH-1:0] rf_rd1,
  output logic                  stall,
  output logic                  clear_done
);

`ifdef REGFILE_SP_INIT_EN
  localparam bit SP_INIT_EN = 1'b1;
`else
  localparam bit SP_INIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {CLEAR, IDLE, DRAIN, ACCESS, ACK} state_t;

  state_t                state_q, state_d;
  logic [4:0]            clr_cnt_q, clr_cnt_d;
  logic                  dbg_ack_q, dbg_ack_d;
  logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
  logic                  clear_done_q, clear_done_d;
  logic                  dbg_we_q, dbg_we_d;
  logic [4:0]            dbg_addr_q, dbg_addr_d;
  logic [DATA_WIDTH-1:0] dbg_wdata_q, dbg_wdata_d;

  // Request fields are captured on acceptance so a dropped dbg_req still completes cleanly.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    dbg_ack_d    = 1'b0;
    dbg_rdata_d  = dbg_rdata_q;
    clear_done_d = clear_done_q;
    dbg_we_d     = dbg_we_q;
    dbg_addr_d   = dbg_addr_q;
    dbg_wdata_d  = dbg_wdata_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == 5'd31) begin
          state_d      = IDLE;
          clear_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + 5'd1;
        end
      end
      IDLE: begin
        if (dbg_req) begin
          state_d     = DRAIN;
          dbg_we_d    = dbg_we;
          dbg_addr_d  = dbg_addr;
          dbg_wdata_d = dbg_wdata;
        end
      end
      DRAIN:  state_d = ACCESS;
      ACCESS: begin
        state_d     = ACK;
        dbg_ack_d   = 1'b1;
        dbg_rdata_d = rf_rd1;
      end
      ACK:     state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= 5'd1;
      dbg_ack_q    <= 1'b0;
      dbg_rdata_q  <= '0;
      clear_done_q <= 1'b0;
      dbg_we_q     <= 1'b0;
      dbg_addr_q   <= '0;
      dbg_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      dbg_ack_q    <= dbg_ack_d;
      dbg_rdata_q  <= dbg_rdata_d;
      clear_done_q <= clear_done_d;
      dbg_we_q     <= dbg_we_d;
      dbg_addr_q   <= dbg_addr_d;
      dbg_wdata_q  <= dbg_wdata_d;
    end
  end

  always_comb begin
    rf_we3 = 1'b0;
    rf_ad3 = wb_addr;
    rf_wd3 = wb_data;
    rf_ad1 = pipe_ad1;
    stall  = 1'b1;
    case (state_q)
      CLEAR: begin
        rf_we3 = 1'b1;
        rf_ad3 = clr_cnt_q;
        rf_wd3 = (SP_INIT_EN && clr_cnt_q == 5'd2) ? SP_INIT : '0;
      end
      IDLE: begin
        rf_we3 = wb_we;
        stall  = 1'b0;
      end
      DRAIN: rf_we3 = wb_we;
      ACCESS: begin
        rf_we3 = dbg_we_q;
        rf_ad3 = dbg_addr_q;
        rf_wd3 = dbg_wdata_q;
        rf_ad1 = dbg_addr_q;
      end
      default: rf_we3 = 1'b0;
    endcase
  end

  assign dbg_ack    = dbg_ack_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign clear_done = clear_done_q;

endmodule
